// File: rtl/perf_counter_sampler.sv
`timescale 1ns/1ps
// perf_counter_sampler: sweeps perf counters FirstIdx..LastIdx and streams them out.
// Define PERF_SAMPLER_CLEAR_ON_READ_EN to zero each counter right after it is read.

module perf_counter_sampler #(
    parameter logic [4:0]  FirstIdx   = 5'd3,
    parameter logic [4:0]  LastIdx    = 5'd18,
    parameter int unsigned TimerWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic [TimerWidth-1:0] interval_i,
    input  logic                  trigger_i,
    input  logic                  debug_mode_i,
    output logic                  perf_req_o,
    input  logic                  perf_gnt_i,
    output logic [4:0]            perf_addr_o,
    output logic                  perf_we_o,
    output logic [63:0]           perf_data_o,
    input  logic [63:0]           perf_data_i,
    output logic                  sample_valid_o,
    input  logic                  sample_ready_i,
    output logic [4:0]            sample_idx_o,
    output logic [63:0]           sample_data_o,
    output logic                  sample_last_o,
    output logic                  busy_o,
    output logic [15:0]           dropped_o
);

    typedef enum logic [1:0] {IDLE, RD, CLR, OUT} state_e;

    state_e                state_q, state_d;
    logic [TimerWidth-1:0] timer_q, timer_d;
    logic [4:0]            idx_q, idx_d;
    logic [63:0]           sample_q, sample_d;
    logic [15:0]           dropped_q, dropped_d;

    logic timer_run;
    logic tick;
    logic sweep_req;
    logic accept;
    logic drop;
    logic at_last;

    assign timer_run = enable_i && (interval_i != '0);
    // ">=" keeps the timer wrapping if interval_i shrinks below the current count
    assign tick      = timer_run && !debug_mode_i &&
                       (timer_q >= interval_i - TimerWidth'(1));
    assign sweep_req = tick || trigger_i;
    assign accept    = sweep_req && (state_q == IDLE) && !debug_mode_i;
    assign drop      = sweep_req && !accept;
    assign at_last   = (idx_q == LastIdx);

    always_comb begin
        timer_d = timer_q;
        if (!timer_run) begin
            timer_d = '0;
        end else if (!debug_mode_i) begin
            timer_d = tick ? '0 : timer_q + TimerWidth'(1);
        end
    end

    always_comb begin
        dropped_d = dropped_q;
        if (drop && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        sample_d       = sample_q;
        perf_req_o     = 1'b0;
        perf_addr_o    = '0;
        perf_we_o      = 1'b0;
        sample_valid_o = 1'b0;
        sample_idx_o   = '0;
        sample_data_o  = '0;
        sample_last_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = FirstIdx;
                    state_d = RD;
                end
            end
            RD: begin
                perf_req_o  = 1'b1;
                perf_addr_o = idx_q;
                if (perf_gnt_i) begin
                    sample_d = perf_data_i;
`ifdef PERF_SAMPLER_CLEAR_ON_READ_EN
                    state_d  = CLR;
`else
                    state_d  = OUT;
`endif
                end
            end
`ifdef PERF_SAMPLER_CLEAR_ON_READ_EN
            // Increments landing between the read and this write are lost
            CLR: begin
                perf_req_o  = 1'b1;
                perf_we_o   = 1'b1;
                perf_addr_o = idx_q;
                if (perf_gnt_i) begin
                    state_d = OUT;
                end
            end
`endif
            OUT: begin
                sample_valid_o = 1'b1;
                sample_idx_o   = idx_q;
                sample_data_o  = sample_q;
                sample_last_o  = at_last;
                if (sample_ready_i) begin
                    if (at_last) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            idx_q     <= FirstIdx;
            sample_q  <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            sample_q  <= sample_d;
            dropped_q <= dropped_d;
        end
    end

    assign perf_data_o = '0;
    assign busy_o      = (state_q != IDLE);
    assign dropped_o   = dropped_q;

endmodule
